// File: rtl/cdc_word_packer_pkg.sv
// Shared helpers for the cdc_word_packer receive-side beat packer.
package cdc_word_packer_pkg;

    function automatic int cntW(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cdc_word_packer.sv
// Packs N_BEATS narrow beats into one wide word behind a registered valid/ready output.
// Optional idle-timeout flush of partial words: define CDC_WORD_PACKER_FLUSH_EN.
module cdc_word_packer
    import cdc_word_packer_pkg::*;
#(
    parameter int IN_W           = 8,
    parameter int N_BEATS        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_cg,
    input  logic [IN_W-1:0]              i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [IN_W*N_BEATS-1:0]      o_data,
    output logic [cntW(N_BEATS)-1:0]     o_nBeats,
    output logic                         o_valid,
    input  logic                         i_ready
);

    localparam int WORD_W = IN_W * N_BEATS;
    localparam int CNT_W  = cntW(N_BEATS - 1);
    localparam int NB_W   = cntW(N_BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BEATS - 1);
    localparam logic [NB_W-1:0]  FULL_N   = NB_W'(N_BEATS);

    if (IN_W < 1 || N_BEATS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cdc_word_packer: illegal parameter value");
    end

    logic [WORD_W-1:0] acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WORD_W-1:0] out_r;
    logic              out_full_r;

    logic              ready_s;
    logic              last_s;
    logic              accept_s;
    logic              drain_s;
    logic              flush_s;
    logic [WORD_W-1:0] merged_s;

    // The stall term depends only on flops, so i_ready never reaches o_ready.
    assign last_s   = (cnt_r == LAST_IDX);
    assign ready_s  = !(out_full_r && last_s);
    assign accept_s = i_cg && i_valid && ready_s;
    assign drain_s  = i_cg && out_full_r && i_ready;

    // Accumulator with the incoming beat merged into the slice selected by cnt_r.
    always_comb begin
        merged_s = acc_r;
        for (int k = 0; k < N_BEATS; k++) begin
            if (cnt_r == CNT_W'(k)) begin
                merged_s[k*IN_W +: IN_W] = i_data;
            end else begin
                merged_s[k*IN_W +: IN_W] = acc_r[k*IN_W +: IN_W];
            end
        end
    end

`ifdef CDC_WORD_PACKER_FLUSH_EN
    localparam int IDLE_W = cntW(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_r;
    logic [NB_W-1:0]   out_n_r;

    assign flush_s = i_cg && (idle_r == IDLE_MAX) && (cnt_r != {CNT_W{1'b0}})
                     && !out_full_r && !accept_s;

    // Saturating idle counter, running only while a partial word is pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_r <= {IDLE_W{1'b0}};
        end else if (i_cg) begin
            if (accept_s || flush_s) begin
                idle_r <= {IDLE_W{1'b0}};
            end else if ((cnt_r != {CNT_W{1'b0}}) && (idle_r != IDLE_MAX)) begin
                idle_r <= idle_r + IDLE_W'(1);
            end else begin
                idle_r <= idle_r;
            end
        end else begin
            idle_r <= idle_r;
        end
    end

    // Beat count of the held word: full on a normal load, partial on a flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_n_r <= FULL_N;
        end else if (accept_s && last_s) begin
            out_n_r <= FULL_N;
        end else if (flush_s) begin
            out_n_r <= NB_W'(cnt_r);
        end else begin
            out_n_r <= out_n_r;
        end
    end

    assign o_nBeats = out_n_r;
`else
    assign flush_s  = 1'b0;
    assign o_nBeats = FULL_N;
`endif

    // Accumulator and beat index; cleared when a word leaves so unfilled slices read as zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_r <= {WORD_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                acc_r <= {WORD_W{1'b0}};
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                acc_r <= merged_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else if (flush_s) begin
            acc_r <= {WORD_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Output holding register; a load never coincides with a drain since o_ready excludes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_r      <= {WORD_W{1'b0}};
            out_full_r <= 1'b0;
        end else if (accept_s && last_s) begin
            out_r      <= merged_s;
            out_full_r <= 1'b1;
        end else if (flush_s) begin
            out_r      <= acc_r;
            out_full_r <= 1'b1;
        end else if (drain_s) begin
            out_r      <= out_r;
            out_full_r <= 1'b0;
        end else begin
            out_r      <= out_r;
            out_full_r <= out_full_r;
        end
    end

    assign o_ready = i_cg && ready_s;
    assign o_valid = i_cg && out_full_r;
    assign o_data  = out_r;

endmodule

// File: tb/tb_cdc_word_packer.sv
// Scoreboard bench for cdc_word_packer: directed test-plan sequences plus random traffic.
module tb_cdc_word_packer;

    localparam int IN_W   = 8;
    localparam int N      = 4;
    localparam int TO     = 16;
    localparam int WORD_W = IN_W * N;

    logic              clk;
    logic              i_rst;
    logic              i_cg;
    logic [IN_W-1:0]   i_data;
    logic              i_valid;
    logic              o_ready;
    logic [WORD_W-1:0] o_data;
    logic [2:0]        o_nBeats;
    logic              o_valid;
    logic              i_ready;

    cdc_word_packer #(.IN_W(IN_W), .N_BEATS(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cg(i_cg), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_nBeats(o_nBeats), .o_valid(o_valid),
        .i_ready(i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] data;
        int                n;
    } exp_t;

    exp_t            exp_q[$];
    logic [IN_W-1:0] m_part[$];
    bit              m_full;
    int              m_idle;
    int              checks;
    int              errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] pack(input int n);
        logic [WORD_W-1:0] w = '0;
        for (int k = 0; k < n; k++) w = w | (WORD_W'(m_part[k]) << (k * IN_W));
        return w;
    endfunction

    // Reference model and monitor: evaluated mid-cycle, describes what the next edge does.
    always @(negedge clk) begin
        bit   exp_ready, exp_valid, beat, word, full_before;
        exp_t e;
        if (i_rst) begin
            exp_q.delete();
            m_part.delete();
            m_full = 0;
            m_idle = 0;
        end else begin
            exp_ready = i_cg && !(m_full && m_part.size() == N - 1);
            exp_valid = i_cg && m_full;
            chk("o_ready", 64'(o_ready), 64'(exp_ready));
            chk("o_valid", 64'(o_valid), 64'(exp_valid));
            beat        = i_cg && i_valid && exp_ready;
            word        = exp_valid && i_ready;
            full_before = m_full;
            if (word) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("o_data", 64'(o_data), 64'(e.data));
                    chk("o_nBeats", 64'(o_nBeats), 64'(e.n));
                end
                m_full = 0;
            end
            if (beat) begin
                m_part.push_back(i_data);
                m_idle = 0;
                if (m_part.size() == N) begin
                    e.data = pack(N);
                    e.n    = N;
                    exp_q.push_back(e);
                    m_part.delete();
                    m_full = 1;
                end
            end
`ifdef CDC_WORD_PACKER_FLUSH_EN
            else if (i_cg && m_part.size() > 0) begin
                if (m_idle == TO && !full_before) begin
                    e.data = pack(m_part.size());
                    e.n    = m_part.size();
                    exp_q.push_back(e);
                    m_part.delete();
                    m_full = 1;
                    m_idle = 0;
                end else if (m_idle < TO) begin
                    m_idle++;
                end
            end
`endif
        end
    end

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [IN_W-1:0] d);
        bit done = 0;
        i_valid = 1'b1;
        i_data  = d;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            done = i_cg && o_ready && !i_rst;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat 0x%0h not accepted, expected acceptance within 64 cycles", d);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; m_full = 0; m_idle = 0;
        i_rst = 1'b1; i_cg = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        tick(3);
        i_rst = 1'b0;

        // 1: back-to-back word
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        @(negedge clk);
        chk("t1_word", 64'(o_data), 64'h44332211);
        chk("t1_nbeats", 64'(o_nBeats), 64'd4);
        tick(2);

        // 2: output held while a second word fills and stalls
        i_ready = 1'b0;
        for (int b = 1; b <= 7; b++) send(IN_W'(b));
        i_valid = 1'b1; i_data = 8'h08;
        tick(3);
        @(negedge clk);
        chk("t2_held", 64'(o_data), 64'h04030201);
        tick(1);
        i_ready = 1'b1;
        send(8'h08);
        tick(3);

        // 3: clock gate low mid-word
        send(8'hA1); send(8'hA2);
        i_cg = 1'b0; i_valid = 1'b1; i_data = 8'hEE;
        tick(5);
        i_cg = 1'b1; i_valid = 1'b0;
        send(8'hA3); send(8'hA4);
        tick(3);

        // 4: reset drops a partial word, beat in the reset cycle ignored
        send(8'hAA); send(8'hBB);
        i_rst = 1'b1; i_valid = 1'b1; i_data = 8'hCC;
        tick(1);
        i_rst = 1'b0; i_valid = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        @(negedge clk);
        chk("t4_word", 64'(o_data), 64'h04030201);
        tick(3);

        // 5/6: idle with a partial word, then a beat at the flush-eligible cycle
        send(8'hAA); send(8'hBB);
        tick(20);
        send(8'h5A);
        tick(16);
        send(8'h5B);
        tick(4);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            i_cg    = ($urandom_range(0, 7) != 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = IN_W'($urandom);
            i_ready = ($urandom_range(0, 2) != 0);
            i_rst   = ($urandom_range(0, 149) == 0);
            tick(1);
        end

        i_rst = 1'b0; i_cg = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        tick(40);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
